// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MA arbiter for the shared memory port; optional MEM_ARB_STARVE_GUARD_EN
module mem_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_if_req,
    input  logic [ADDR_W-1:0] iw_if_addr,
    input  logic              iw_if_flush,
    output logic              ow_if_ack,
    output logic [DATA_W-1:0] ow_if_rdata,
    input  logic              iw_ma_req,
    input  logic              iw_ma_we,
    input  logic [ADDR_W-1:0] iw_ma_addr,
    input  logic [DATA_W-1:0] iw_ma_wdata,
    output logic              ow_ma_ack,
    output logic [DATA_W-1:0] ow_ma_rdata,
    output logic              ow_mem_req,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic              iw_mem_ack,
    input  logic [DATA_W-1:0] iw_mem_rdata,
    output logic              ow_busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_MA = 1'b1;

    state_t            r_state;
    logic              r_owner;
    logic              r_drop;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;

    logic w_if_elig;
    logic w_ma_elig;
    logic w_force_if;
    logic w_grant_ma;
    logic w_grant_if;
    logic w_done;

    // A fetch that is being flushed this very cycle is not worth starting.
    assign w_if_elig = iw_if_req & ~iw_if_flush;
    assign w_ma_elig = iw_ma_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] r_starve;

    assign w_force_if = (int'(r_starve) >= STARVE_LIMIT) & w_if_elig & w_ma_elig;

    // Counts MA wins taken while IF was waiting; only grant edges move it.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_starve <= 3'd0;
        end else if (!iw_if_req) begin
            r_starve <= 3'd0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_if) begin
                r_starve <= 3'd0;
            end else if (w_grant_ma && w_if_elig && (r_starve != 3'd7)) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    assign w_grant_ma = w_ma_elig & ~w_force_if;
    assign w_grant_if = w_if_elig & ~w_grant_ma;

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_drop      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_ma) begin
                        r_state     <= S_BUSY;
                        r_owner     <= OWN_MA;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mem_we    <= iw_ma_we;
                        r_mem_addr  <= iw_ma_addr;
                        r_mem_wdata <= iw_ma_wdata;
                    end else if (w_grant_if) begin
                        r_state     <= S_BUSY;
                        r_owner     <= OWN_IF;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= iw_if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                S_BUSY: begin
                    if (iw_mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_drop    <= 1'b0;
                    end else if ((r_owner == OWN_IF) && iw_if_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Completion is only meaningful while a transaction is actually in flight.
    assign w_done = iw_rst_n & (r_state == S_BUSY) & iw_mem_ack;

    assign ow_if_ack   = w_done & (r_owner == OWN_IF) & ~r_drop & ~iw_if_flush;
    assign ow_ma_ack   = w_done & (r_owner == OWN_MA);
    assign ow_if_rdata = ow_if_ack ? iw_mem_rdata : '0;
    assign ow_ma_rdata = ow_ma_ack ? iw_mem_rdata : '0;

    assign ow_mem_req   = r_mem_req;
    assign ow_mem_we    = r_mem_we;
    assign ow_mem_addr  = r_mem_addr;
    assign ow_mem_wdata = r_mem_wdata;
    assign ow_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, ma_req, ma_we, mem_ack;
    logic [23:0] if_addr, ma_addr, ma_wdata, mem_rdata;
    logic        if_ack, ma_ack, mem_req, mem_we, busy;
    logic [23:0] if_rdata, ma_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(24), .DATA_W(24), .STARVE_LIMIT(4)) dut (
        .iw_clk      (clk),
        .iw_rst_n    (rst_n),
        .iw_if_req   (if_req),
        .iw_if_addr  (if_addr),
        .iw_if_flush (if_flush),
        .ow_if_ack   (if_ack),
        .ow_if_rdata (if_rdata),
        .iw_ma_req   (ma_req),
        .iw_ma_we    (ma_we),
        .iw_ma_addr  (ma_addr),
        .iw_ma_wdata (ma_wdata),
        .ow_ma_ack   (ma_ack),
        .ow_ma_rdata (ma_rdata),
        .ow_mem_req  (mem_req),
        .ow_mem_we   (mem_we),
        .ow_mem_addr (mem_addr),
        .ow_mem_wdata(mem_wdata),
        .iw_mem_ack  (mem_ack),
        .iw_mem_rdata(mem_rdata),
        .ow_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, mem_req}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},    32'd0);
        chk({tag, "_ifack"}, {31'd0, if_ack},  32'd0);
        chk({tag, "_maack"}, {31'd0, ma_ack},  32'd0);
    endtask

    initial begin
        int  m;
        bit  exp_if;
        rst_n = 1'b0; if_req = 0; if_flush = 0; ma_req = 0; ma_we = 0; mem_ack = 0;
        if_addr = '0; ma_addr = '0; ma_wdata = '0; mem_rdata = '0;
        step; step;
        #1;
        chk_idle_outputs("reset");
        chk("reset_we",    {31'd0, mem_we}, 32'd0);
        chk("reset_addr",  {8'd0, mem_addr}, 32'd0);
        chk("reset_wdata", {8'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;

        // Single fetch, memory acks 2 cycles after req rises
        step;
        if_req = 1; if_addr = 24'h000010; #1;
        chk("t1_c0_req", {31'd0, mem_req}, 32'd0);
        step; #1;
        chk("t1_c1_req",  {31'd0, mem_req}, 32'd1);
        chk("t1_c1_busy", {31'd0, busy}, 32'd1);
        chk("t1_c1_we",   {31'd0, mem_we}, 32'd0);
        chk("t1_c1_addr", {8'd0, mem_addr}, 32'h10);
        step; #1;
        chk("t1_c2_ack", {31'd0, if_ack}, 32'd0);
        step;
        mem_ack = 1; mem_rdata = 24'hABCDEF; #1;
        chk("t1_c3_ack",   {31'd0, if_ack}, 32'd1);
        chk("t1_c3_rdata", {8'd0, if_rdata}, 32'hABCDEF);
        chk("t1_c3_maack", {31'd0, ma_ack}, 32'd0);
        chk("t1_c3_req",   {31'd0, mem_req}, 32'd1);
        step;
        mem_ack = 0; if_req = 0; #1;
        chk_idle_outputs("t1_c4");
        chk("t1_c4_rdata", {8'd0, if_rdata}, 32'd0);

        // Simultaneous IF fetch and MA store: MA first
        step;
        if_req = 1; if_addr = 24'h000020;
        ma_req = 1; ma_we = 1; ma_addr = 24'h000100; ma_wdata = 24'h123456; #1;
        step; #1;
        chk("t2_ma_req",   {31'd0, mem_req}, 32'd1);
        chk("t2_ma_we",    {31'd0, mem_we}, 32'd1);
        chk("t2_ma_addr",  {8'd0, mem_addr}, 32'h100);
        chk("t2_ma_wdata", {8'd0, mem_wdata}, 32'h123456);
        step;
        mem_ack = 1; mem_rdata = 24'h000777; #1;
        chk("t2_ma_ack",   {31'd0, ma_ack}, 32'd1);
        chk("t2_ma_rdata", {8'd0, ma_rdata}, 32'h777);
        chk("t2_if_noack", {31'd0, if_ack}, 32'd0);
        step;
        mem_ack = 0; ma_req = 0; ma_we = 0; #1;
        chk("t2_gap_req", {31'd0, mem_req}, 32'd0);
        step; #1;
        chk("t2_if_req",   {31'd0, mem_req}, 32'd1);
        chk("t2_if_we",    {31'd0, mem_we}, 32'd0);
        chk("t2_if_addr",  {8'd0, mem_addr}, 32'h20);
        chk("t2_if_wdata", {8'd0, mem_wdata}, 32'd0);
        step;
        mem_ack = 1; mem_rdata = 24'h0000AA; #1;
        chk("t2_if_ack", {31'd0, if_ack}, 32'd1);
        step;
        mem_ack = 0; if_req = 0; #1;

        // Flush one cycle before completion
        step;
        if_req = 1; if_addr = 24'h000030; #1;
        step;
        if_flush = 1; #1;
        chk("t3_busy", {31'd0, busy}, 32'd1);
        step;
        if_flush = 0; if_req = 0; mem_ack = 1; mem_rdata = 24'h555555; #1;
        chk("t3_drop_ack",   {31'd0, if_ack}, 32'd0);
        chk("t3_drop_rdata", {8'd0, if_rdata}, 32'd0);
        step;
        mem_ack = 0; if_req = 1; if_addr = 24'h000040; #1;
        chk_idle_outputs("t3_idle");
        step; #1;
        chk("t3_next_addr", {8'd0, mem_addr}, 32'h40);
        step;
        mem_ack = 1; mem_rdata = 24'h0BEEF0; #1;
        chk("t3_next_ack",   {31'd0, if_ack}, 32'd1);
        chk("t3_next_rdata", {8'd0, if_rdata}, 32'h0BEEF0);
        step;
        mem_ack = 0; #1;

        // Flush in the same cycle as completion (IF still requesting addr 0x40)
        step; #1;
        chk("t3b_req", {31'd0, mem_req}, 32'd1);
        step;
        mem_ack = 1; if_flush = 1; #1;
        chk("t3b_ack", {31'd0, if_ack}, 32'd0);
        step;
        mem_ack = 0; if_flush = 0; if_req = 0; #1;
        chk_idle_outputs("t3b_idle");

        // Reset mid-transaction, late completion ignored
        step;
        ma_req = 1; ma_we = 0; ma_addr = 24'h000050; #1;
        step;
        rst_n = 0; #1;
        chk("t4_busy_before", {31'd0, busy}, 32'd1);
        step;
        rst_n = 1; ma_req = 0; mem_ack = 1; mem_rdata = 24'h999999; #1;
        chk_idle_outputs("t4_after");
        chk("t4_addr", {8'd0, mem_addr}, 32'd0);
        step;
        mem_ack = 0; #1;
        chk_idle_outputs("t4_settle");

        // Back-to-back MA loads with IF pending, single-cycle memory
        step;
        m = 0;
        if_req = 1; if_addr = 24'h000060;
        ma_req = 1; ma_we = 0; ma_addr = 24'h000200;
        for (int g = 0; g < 7; g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (g == 4);
`else
            exp_if = (g == 6);
`endif
            #1;
            chk("t5_idle_req", {31'd0, mem_req}, 32'd0);
            step; #1;
            chk("t5_grant_addr", {8'd0, mem_addr}, exp_if ? 32'h60 : 32'h200 + 32'(m));
            step;
            mem_ack = 1; mem_rdata = 24'(g + 1); #1;
            chk("t5_if_ack", {31'd0, if_ack}, {31'd0, exp_if});
            chk("t5_ma_ack", {31'd0, ma_ack}, {31'd0, !exp_if});
            step;
            mem_ack = 0;
            if (exp_if) begin
                if_req = 0;
            end else begin
                m++;
                ma_addr = 24'h000200 + 24'(m);
                if (m == 6) ma_req = 0;
            end
        end
        #1;
        chk_idle_outputs("t5_end");
        chk("t5_ma_count", 32'(m), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
